// File: rtl/as2650_mbox_pkg.sv
// Shared register map and status-bit layout for the AS2650 Wishbone mailbox.
package as2650_mbox_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQEN  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // WB STATUS positions assume 4-bit count fields; wider counts shift the flags up.
  localparam int ST_M2C_CNT   = 0;
  localparam int ST_C2M_CNT   = 4;
  localparam int ST_M2C_OVF   = 8;
  localparam int ST_C2M_OVF   = 9;
  localparam int ST_M2C_FULL  = 10;
  localparam int ST_C2M_EMPTY = 11;

  localparam int CPU_C2M_OVF   = 0;
  localparam int CPU_M2C_OVF   = 1;
  localparam int CPU_C2M_FULL  = 2;
  localparam int CPU_M2C_EMPTY = 3;

  function automatic int st_field_w(input int cnt_w);
    return (cnt_w > 4) ? cnt_w : 4;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Byte-wide synchronous FIFO; simultaneous push+pop on a full FIFO is not an overflow.
module mbox_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [7:0]             din_i,
  output logic [7:0]             dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push_s, do_pop_s;

  assign empty_o   = (cnt_q == {CW{1'b0}});
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign do_pop_s  = pop_i & ~empty_o;
  // A full FIFO is never empty, so a concurrent pop always frees the slot.
  assign do_push_s = push_i & (~full_o | pop_i);
  assign ovf_o     = push_i & full_o & ~pop_i & ~flush_i;
  assign dout_o    = empty_o ? 8'h00 : mem_q[rd_q];
  assign count_o   = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = {AW{1'b0}};
      wr_d  = {AW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else begin
      rd_d  = do_pop_s  ? rd_q + AW'(1) : rd_q;
      wr_d  = do_push_s ? wr_q + AW'(1) : wr_q;
      cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= {AW{1'b0}};
      wr_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s & ~flush_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/as2650_wb_mailbox.sv
// Wishbone-to-AS2650 mailbox: M2C and C2M byte FIFOs, sticky overflow flags and IRQs.
module as2650_wb_mailbox
  import as2650_mbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_irq,
  output logic        user_irq0
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int FW  = st_field_w(CW);
  localparam int OFS = 2 * (FW - 4);

  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          m2c_ovf_q, m2c_ovf_d, c2m_ovf_q, c2m_ovf_d;
  logic [1:0]    irq_en_q, irq_en_d;
  logic          cpu_irq_q, cpu_irq_d, user_irq_q, user_irq_d;

  logic          accept_s, wr_s, rd_s, flush_s, w1c_s;
  logic [1:0]    reg_s;
  logic [31:0]   status_s, rdata_s;
  logic [7:0]    m2c_dout_s, c2m_dout_s;
  logic [CW-1:0] m2c_cnt_s, c2m_cnt_s;
  logic          m2c_full_s, m2c_empty_s, m2c_ovfp_s;
  logic          c2m_full_s, c2m_empty_s, c2m_ovfp_s;
  logic          unused_s;

  assign accept_s = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wr_s     = accept_s & wbs_we_i;
  assign rd_s     = accept_s & ~wbs_we_i;
  assign reg_s    = wbs_adr_i[3:2];
  assign flush_s  = wr_s & (reg_s == REG_CTRL) & wbs_dat_i[0];
  assign w1c_s    = wr_s & (reg_s == REG_STATUS);
  assign unused_s = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:10], wbs_sel_i[3:1]};

  mbox_fifo #(.DEPTH(DEPTH)) u_m2c (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (wr_s & (reg_s == REG_DATA) & wbs_sel_i[0]),
    .pop_i   (cpu_rd & ~cpu_addr),
    .flush_i (flush_s),
    .din_i   (wbs_dat_i[7:0]),
    .dout_o  (m2c_dout_s),
    .count_o (m2c_cnt_s),
    .full_o  (m2c_full_s),
    .empty_o (m2c_empty_s),
    .ovf_o   (m2c_ovfp_s)
  );

  mbox_fifo #(.DEPTH(DEPTH)) u_c2m (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (cpu_wr & ~cpu_addr),
    .pop_i   (rd_s & (reg_s == REG_DATA)),
    .flush_i (flush_s),
    .din_i   (cpu_din),
    .dout_o  (c2m_dout_s),
    .count_o (c2m_cnt_s),
    .full_o  (c2m_full_s),
    .empty_o (c2m_empty_s),
    .ovf_o   (c2m_ovfp_s)
  );

  always_comb begin
    status_s = 32'd0;
    status_s[ST_M2C_CNT +: FW]            = FW'(m2c_cnt_s);
    status_s[ST_C2M_CNT + FW - 4 +: FW]   = FW'(c2m_cnt_s);
    status_s[ST_M2C_OVF + OFS]            = m2c_ovf_q;
    status_s[ST_C2M_OVF + OFS]            = c2m_ovf_q;
    status_s[ST_M2C_FULL + OFS]           = m2c_full_s;
    status_s[ST_C2M_EMPTY + OFS]          = c2m_empty_s;
  end

  always_comb begin
    rdata_s = 32'd0;
    if (rd_s) begin
      case (reg_s)
        REG_DATA:   rdata_s = {24'd0, c2m_dout_s};
        REG_STATUS: rdata_s = status_s;
        REG_IRQEN:  rdata_s = {30'd0, irq_en_q};
        REG_CTRL:   rdata_s = 32'd0;
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // A new overflow in the same cycle as its W1C clear leaves the flag set.
  always_comb begin
    ack_d      = accept_s;
    dat_d      = rdata_s;
    m2c_ovf_d  = (m2c_ovf_q & ~(w1c_s & wbs_dat_i[8])) | m2c_ovfp_s;
    c2m_ovf_d  = (c2m_ovf_q & ~(w1c_s & wbs_dat_i[9])) | c2m_ovfp_s;
    irq_en_d   = (wr_s && (reg_s == REG_IRQEN)) ? wbs_dat_i[1:0] : irq_en_q;
    cpu_irq_d  = ~m2c_empty_s;
    user_irq_d = (irq_en_q[0] & ~c2m_empty_s) | (irq_en_q[1] & (m2c_ovf_q | c2m_ovf_q));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      m2c_ovf_q  <= 1'b0;
      c2m_ovf_q  <= 1'b0;
      irq_en_q   <= 2'd0;
      cpu_irq_q  <= 1'b0;
      user_irq_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      m2c_ovf_q  <= m2c_ovf_d;
      c2m_ovf_q  <= c2m_ovf_d;
      irq_en_q   <= irq_en_d;
      cpu_irq_q  <= cpu_irq_d;
      user_irq_q <= user_irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign cpu_irq   = cpu_irq_q;
  assign user_irq0 = user_irq_q;

  always_comb begin
    cpu_dout = 8'h00;
    if (cpu_addr) begin
      cpu_dout[CPU_C2M_OVF]   = c2m_ovf_q;
      cpu_dout[CPU_M2C_OVF]   = m2c_ovf_q;
      cpu_dout[CPU_C2M_FULL]  = c2m_full_s;
      cpu_dout[CPU_M2C_EMPTY] = m2c_empty_s;
    end else begin
      cpu_dout = m2c_dout_s;
    end
  end

endmodule

// File: tb/tb_as2650_wb_mailbox.sv
// Directed + randomized bench for as2650_wb_mailbox against a queue-based mailbox model.
module tb_as2650_wb_mailbox;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i, dat_o;
  logic        ack;
  logic        cpu_rd, cpu_wr, cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_irq, user_irq0;

  int tests = 0;
  int fails = 0;

  logic [7:0] m2c[$];
  logic [7:0] c2m[$];
  bit         m_ovf_m2c, m_ovf_c2m;
  bit [1:0]   m_en;

  logic [31:0] r;
  logic [7:0]  c;

  as2650_wb_mailbox #(.DEPTH(DEPTH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_irq   (cpu_irq),
    .user_irq0 (user_irq0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'd0;
    s[3:0] = 4'(m2c.size());
    s[7:4] = 4'(c2m.size());
    s[8]   = m_ovf_m2c;
    s[9]   = m_ovf_c2m;
    s[10]  = (m2c.size() == DEPTH);
    s[11]  = (c2m.size() == 0);
    return s;
  endfunction

  function automatic logic m_user_irq();
    return (m_en[0] && c2m.size() != 0) || (m_en[1] && (m_ovf_m2c || m_ovf_c2m));
  endfunction

  task automatic idle();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat_i = 32'd0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 1'b0; cpu_din = 8'h00;
  endtask

  task automatic model_reset();
    m2c.delete(); c2m.delete();
    m_ovf_m2c = 1'b0; m_ovf_c2m = 1'b0; m_en = 2'd0;
  endtask

  // One WB access and/or CPU strobe sharing a single clock edge; starts and ends 1 after a posedge.
  task automatic xact(input bit wb_en, input bit w, input logic [1:0] rg, input logic [31:0] d,
                      input logic [3:0] s, input bit crd, input bit cwr, input bit ca,
                      input logic [7:0] cd, output logic [31:0] wb_obs, output logic [7:0] cpu_obs);
    logic [31:0] exp_rd;
    logic [7:0]  exp_cpu;
    bit m2c_push, m2c_pop, c2m_push, c2m_pop, flush, ovf_m, ovf_c;
    stb = wb_en; cyc = wb_en; we = w; adr = {28'd0, rg, 2'b00}; dat_i = d; sel = s;
    cpu_rd = crd; cpu_wr = cwr; cpu_addr = ca; cpu_din = cd;
    #1;
    if (ca) exp_cpu = {4'd0, m2c.size() == 0, c2m.size() == DEPTH, m_ovf_m2c, m_ovf_c2m};
    else    exp_cpu = (m2c.size() != 0) ? m2c[0] : 8'h00;
    cpu_obs = cpu_dout;
    check("cpu_dout", {24'd0, cpu_obs}, {24'd0, exp_cpu});
    exp_rd = 32'd0;
    if (wb_en && !w) begin
      if (rg == 2'd0)      exp_rd = (c2m.size() != 0) ? {24'd0, c2m[0]} : 32'd0;
      else if (rg == 2'd1) exp_rd = m_status();
      else if (rg == 2'd2) exp_rd = {30'd0, m_en};
    end
    m2c_push = wb_en && w && rg == 2'd0 && s[0];
    m2c_pop  = crd && !ca;
    c2m_push = cwr && !ca;
    c2m_pop  = wb_en && !w && rg == 2'd0;
    flush    = wb_en && w && rg == 2'd3 && d[0];
    @(posedge clk); #1;
    wb_obs = dat_o;
    if (wb_en) begin
      check("wb_ack", {31'd0, ack}, 32'd1);
      check("wb_dat", wb_obs, exp_rd);
    end
    idle();
    ovf_m = 1'b0; ovf_c = 1'b0;
    if (flush) begin
      m2c.delete(); c2m.delete();
    end else begin
      if (m2c_pop && m2c.size() > 0) void'(m2c.pop_front());
      if (m2c_push) begin
        if (m2c.size() < DEPTH) m2c.push_back(d[7:0]); else ovf_m = 1'b1;
      end
      if (c2m_pop && c2m.size() > 0) void'(c2m.pop_front());
      if (c2m_push) begin
        if (c2m.size() < DEPTH) c2m.push_back(cd); else ovf_c = 1'b1;
      end
    end
    if (wb_en && w && rg == 2'd1) begin
      if (d[8]) m_ovf_m2c = 1'b0;
      if (d[9]) m_ovf_c2m = 1'b0;
    end
    m_ovf_m2c = m_ovf_m2c || ovf_m;
    m_ovf_c2m = m_ovf_c2m || ovf_c;
    if (wb_en && w && rg == 2'd2) m_en = d[1:0];
    @(posedge clk); #1;
    check("ack_low", {31'd0, ack}, 32'd0);
    check("dat_idle", dat_o, 32'd0);
    check("cpu_irq", {31'd0, cpu_irq}, {31'd0, m2c.size() != 0});
    check("user_irq0", {31'd0, user_irq0}, {31'd0, m_user_irq()});
  endtask

  task automatic wbw(input logic [1:0] rg, input logic [31:0] d);
    logic [31:0] rr; logic [7:0] cc;
    xact(1'b1, 1'b1, rg, d, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, rr, cc);
  endtask

  task automatic wbr(input logic [1:0] rg, output logic [31:0] rd);
    logic [7:0] cc;
    xact(1'b1, 1'b0, rg, 32'd0, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, rd, cc);
  endtask

  task automatic cpuw(input logic [7:0] v);
    logic [31:0] rr; logic [7:0] cc;
    xact(1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, v, rr, cc);
  endtask

  task automatic cpur(output logic [7:0] v);
    logic [31:0] rr;
    xact(1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, rr, v);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
    check("rst_user_irq", {31'd0, user_irq0}, 32'd0);
    check("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    wbr(2'd1, r); check("status_reset", r, 32'h0000_0800);

    wbw(2'd0, 32'h11); wbw(2'd0, 32'h22);
    check("cpu_irq_set", {31'd0, cpu_irq}, 32'd1);
    cpur(c); check("cpu_rd0", {24'd0, c}, 32'h11);
    cpur(c); check("cpu_rd1", {24'd0, c}, 32'h22);
    check("cpu_irq_clr", {31'd0, cpu_irq}, 32'd0);

    for (int i = 0; i < 9; i++) cpuw(8'(i));
    wbr(2'd1, r); check("status_c2m_ovf", r, 32'h0000_0280);
    for (int i = 0; i < 8; i++) begin
      wbr(2'd0, r); check("c2m_pop", r, 32'(i));
    end
    wbr(2'd0, r); check("c2m_pop_empty", r, 32'd0);
    wbw(2'd1, 32'h200);
    wbr(2'd1, r); check("status_w1c", r, 32'h0000_0800);

    wbw(2'd2, 32'd1);
    cpuw(8'hA5);
    check("user_irq_set", {31'd0, user_irq0}, 32'd1);
    wbr(2'd0, r); check("c2m_a5", r, 32'h0000_00A5);
    check("user_irq_clr", {31'd0, user_irq0}, 32'd0);

    for (int i = 0; i < 8; i++) cpuw(8'h30 + 8'(i));
    xact(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0, 8'h40, r, c);
    check("full_pushpop_head", r, 32'h30);
    wbr(2'd1, r); check("status_full_pushpop", r, 32'h0000_0080);
    xact(1'b1, 1'b1, 2'd0, 32'h5A, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00, r, c);
    check("empty_pushpop_cpu", {24'd0, c}, 32'd0);
    wbr(2'd1, r); check("status_empty_pushpop", r, 32'h0000_0081);
    cpuw(8'h41);
    wbw(2'd3, 32'd1);
    wbr(2'd1, r); check("status_flush", r, 32'h0000_0A00);
    wbw(2'd1, 32'h300);

    wbw(2'd0, 32'h66);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'd0; dat_i = 32'h77; sel = 4'h1;
    @(posedge clk); #1;
    check("mid_ack_high", {31'd0, ack}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_ack_drop", {31'd0, ack}, 32'd0);
    idle();
    model_reset();
    @(posedge clk); #1;
    check("mid_cpu_irq", {31'd0, cpu_irq}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    wbr(2'd1, r); check("status_after_rst", r, 32'h0000_0800);

    for (int i = 0; i < 400; i++) begin
      bit          fill, wb_en, w, crd, cwr, ca;
      logic [1:0]  rg;
      logic [31:0] d;
      fill  = (i % 100) < 50;
      wb_en = ($urandom_range(0, 3) != 0);
      w     = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rg    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      d     = $urandom();
      if (rg == 2'd3) d[0] = ($urandom_range(0, 7) == 0);
      crd   = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cwr   = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ca    = ($urandom_range(0, 4) == 0);
      xact(wb_en, w, rg, d, 4'($urandom_range(0, 15)), crd, cwr, ca, 8'($urandom()), r, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
